// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single ROM read port between the fetch stage
// (requester 0) and a data-read requester (requester 1). Grants at most one read
// per cycle, tracks in-flight reads with a MEM_LAT-deep tag pipeline and routes
// each returning ROM word to the requester that issued it.
// Build option: define ARB_RR_EN for round-robin tie-breaking; without it the
// data requester (m1) always wins a tie.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [15:0]       o_stall_cnt
);

    logic               r_last_gnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_stall_cnt;
    logic [MEM_LAT-1:0] r_tag_vld;
    logic [MEM_LAT-1:0] r_tag_own;

    logic w_m1_wins;
    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;
    logic w_stall;
    logic w_out_vld;
    logic w_out_own;

`ifdef ARB_RR_EN
    // On a tie, grant the requester that was not granted most recently.
    assign w_m1_wins = ~r_last_gnt;
`else
    // Fixed priority: data reads win every tie; last_gnt is tracked but unused here.
    assign w_m1_wins = 1'b1;
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = r_last_gnt;
`endif

    // Grant decode and ROM address mux; grants are held off while in reset.
    always_comb begin
        w_gnt1    = ~i_reset & i_m1_req & (~i_m0_req | w_m1_wins);
        w_gnt0    = ~i_reset & i_m0_req & ~(i_m1_req & w_m1_wins);
        w_any_gnt = w_gnt0 | w_gnt1;
        w_stall   = (i_m0_req & ~w_gnt0) | (i_m1_req & ~w_gnt1);
        if (w_gnt0) begin
            o_mem_addr = i_m0_addr;
        end else if (w_gnt1) begin
            o_mem_addr = i_m1_addr;
        end else begin
            o_mem_addr = r_addr;
        end
    end

    // Arbitration state and last-issued address, both updated only on grants.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_gnt <= 1'b1;
            r_addr     <= '0;
        end else if (w_any_gnt) begin
            r_last_gnt <= w_gnt1;
            r_addr     <= o_mem_addr;
        end
    end

    // Tag pipeline: stage 0 captures {grant, owner}, later stages shift every cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld[0] <= w_any_gnt;
            r_tag_own[0] <= w_gnt1;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
            end
        end
    end

    // Saturating count of cycles in which any active request was refused.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Steer the returning ROM word to the owner of the output tag stage.
    always_comb begin
        w_out_vld   = r_tag_vld[MEM_LAT-1];
        w_out_own   = r_tag_own[MEM_LAT-1];
        o_m0_rvalid = w_out_vld & ~w_out_own;
        o_m1_rvalid = w_out_vld & w_out_own;
        o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
        o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
    end

    assign o_m0_gnt    = w_gnt0;
    assign o_m1_gnt    = w_gnt1;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (two-stage ROM latency build).
// The driver checks grants/address each cycle and queues expected read returns;
// a negedge monitor pops the queue whenever the DUT presents rvalid.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    typedef struct {
        bit                owner;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       stall_cnt;

    logic [DATA_W-1:0] rom_pipe [MEM_LAT];
    exp_t              sb_q [$];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_m0_req    (m0_req),
        .i_m0_addr   (m0_addr),
        .o_m0_gnt    (m0_gnt),
        .o_m0_rvalid (m0_rvalid),
        .o_m0_rdata  (m0_rdata),
        .i_m1_req    (m1_req),
        .i_m1_addr   (m1_addr),
        .o_m1_gnt    (m1_gnt),
        .o_m1_rvalid (m1_rvalid),
        .o_m1_rdata  (m1_rdata),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: word at address a is a>>2, returned MEM_LAT cycles later.
    always @(posedge clk) begin
        rom_pipe[0] <= mem_addr >> 2;
        for (int i = 1; i < MEM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign mem_rdata = rom_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest queued read, on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid || m1_rvalid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rvalid_owner", 64'({m1_rvalid, m0_rvalid}), e.owner ? 64'd2 : 64'd1);
                check("rdata", 64'(e.owner ? m1_rdata : m0_rdata), 64'(e.data));
                check("rdata_other_zero", 64'(e.owner ? m0_rdata : m1_rdata), 64'd0);
                check("rvalid_cycle", 64'(cyc), 64'(e.due));
            end
        end else begin
            check("rdata_idle_zero", {m1_rdata, m0_rdata}, 64'd0);
            if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                check("rvalid_missing", 64'd0, 64'd1);
                void'(sb_q.pop_front());
            end
        end
    end

    // One cycle of stimulus: drive, check grants/address at negedge, queue returns.
    task automatic step(input bit r0, input logic [ADDR_W-1:0] a0, input bit r1,
                        input logic [ADDR_W-1:0] a1, input bit eg0, input bit eg1,
                        input logic [ADDR_W-1:0] eaddr);
        m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1;
        @(negedge clk);
        check("m0_gnt", 64'(m0_gnt), 64'(eg0));
        check("m1_gnt", 64'(m1_gnt), 64'(eg1));
        check("mem_addr", 64'(mem_addr), 64'(eaddr));
        if (eg0) sb_q.push_back('{1'b0, a0 >> 2, cyc + MEM_LAT});
        if (eg1) sb_q.push_back('{1'b1, a1 >> 2, cyc + MEM_LAT});
        @(posedge clk); #1;
    endtask

    task automatic idle_stall(input logic [15:0] exp);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        check("stall_cnt", 64'(stall_cnt), 64'(exp));
        @(posedge clk); #1;
    endtask

    // Tie winner in contention loops; both loops start right after an m0 grant.
    function automatic bit tie_m1(input int k);
`ifdef ARB_RR_EN
        return (k % 2) == 0;
`else
        return (k >= 0);
`endif
    endfunction

    initial begin
        bit eg1;
        reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must not be granted.
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h40; m1_addr = 32'h44;
        @(negedge clk);
        check("rst_m0_gnt", 64'(m0_gnt), 64'd0);
        check("rst_m1_gnt", 64'(m1_gnt), 64'd0);
        check("rst_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0; reset = 1'b0;

        // m0 alone, back-to-back: words 0,1,2 return to m0.
        step(1, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        step(1, 32'h4, 0, 32'h0, 1, 0, 32'h4);
        step(1, 32'h8, 0, 32'h0, 1, 0, 32'h8);
        repeat (3) step(0, 32'h0, 0, 32'h0, 0, 0, 32'h8);
        idle_stall(16'd0);

        // Continuous contention, six cycles: one stall per cycle.
        for (int k = 0; k < 6; k++) begin
            eg1 = tie_m1(k);
            step(1, 32'h10, 1, 32'h20, !eg1, eg1, eg1 ? 32'h20 : 32'h10);
        end
        idle_stall(16'd6);
        eg1 = tie_m1(5);
        repeat (2) step(0, 32'h0, 0, 32'h0, 0, 0, eg1 ? 32'h20 : 32'h10);

        // Single m1 grant of 0x24, then idle: address holds, one response only.
        step(0, 32'h0, 1, 32'h24, 0, 1, 32'h24);
        repeat (4) step(0, 32'h0, 0, 32'h0, 0, 0, 32'h24);
        idle_stall(16'd6);

        // Reset one cycle after an m1 grant: the in-flight read is dropped.
        m1_req = 1'b1; m1_addr = 32'h30;
        @(negedge clk);
        check("pre_rst_m1_gnt", 64'(m1_gnt), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1; m1_req = 1'b0;
        @(negedge clk);
        check("rst_mid_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_drop_m1_rvalid", 64'(m1_rvalid), 64'd0);
        check("rst_drop_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First tie after reset: round-robin gives m0, fixed priority gives m1.
`ifdef ARB_RR_EN
        step(1, 32'h50, 1, 32'h54, 1, 0, 32'h50);
        step(0, 32'h0, 0, 32'h0, 0, 0, 32'h50);
`else
        step(1, 32'h50, 1, 32'h54, 0, 1, 32'h54);
        step(0, 32'h0, 0, 32'h0, 0, 0, 32'h54);
`endif
        idle_stall(16'd1);

        // Long contention drives the stall counter into saturation.
        for (int k = 0; k < 65540; k++) begin
            eg1 = tie_m1(k);
            step(1, 32'h10, 1, 32'h20, !eg1, eg1, eg1 ? 32'h20 : 32'h10);
        end
        idle_stall(16'hFFFF);
        idle_stall(16'hFFFF);

        repeat (MEM_LAT + 2) idle_stall(16'hFFFF);
        check("scoreboard_drain", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single instruction ROM read port between the ezpipe fetch stage (requester 0) and a data-read requester (requester 1). It grants at most one request per cycle, drives the ROM address, tracks in-flight reads through a fixed-latency tag pipeline, and routes each ROM word back to the requester that issued it. It sits between ezpipe and rom, replacing the direct ibus_addr/ibus_data wiring.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, ROM read latency in cycles (≥1); rom registers its output, so 1 is the nominal value
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- m0_req  input  1  fetch request; held with m0_addr stable until granted
- m0_addr  input  ADDR_W  fetch address
- m0_gnt  output  1  fetch request accepted this cycle (combinational)
- m0_rvalid  output  1  fetch read data valid
- m0_rdata  output  DATA_W  fetch read data
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as m0, for data reads
- mem_addr  output  ADDR_W  ROM address
- mem_rdata  input  DATA_W  ROM output; reflects the address presented MEM_LAT cycles earlier
- stall_cnt  output  16  saturating count of cycles in which a request was refused

## Operation
- Grant: exactly one of the following each cycle.
  - No request: no grant.
  - Single request: that requester is granted.
  - Both requesting: the arbitration policy picks the winner (see Configuration).
- m0_gnt and m1_gnt are never both high. A grant depends only on the current req and the arbitration state; there is no back-pressure from the ROM.
- mem_addr:
  - In a grant cycle it equals the granted requester's address (combinational mux).
  - Otherwise it holds a registered last-issued address, which updates on every grant. Reset value is 0.
- Tag pipeline:
  - MEM_LAT stages of {valid, owner}. Stage 0 loads {grant, granted index} every cycle; the stages shift every cycle.
  - Output stage valid and owner==k drives mk_rvalid=1 and mk_rdata=mem_rdata.
  - The non-owning requester sees rvalid=0 and rdata=0.
- Throughput: one read per cycle. Back-to-back grants to the same or different requesters are legal.
- stall_cnt increments by 1 on each cycle with (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt). It saturates at 0xFFFF.
- Arbitration state last_gnt (1 bit) records the most recent granted index. It updates only in grant cycles.
- Reset, in the cycle reset is sampled high:
  - All tag stages cleared. In-flight reads are dropped and their data is never delivered.
  - last_gnt=1, so m0 wins the first tie.
  - mem_addr register cleared to 0; stall_cnt cleared to 0.
  - Grants are suppressed while reset is high.

## Timing
- Request granted in cycle t: mk_rvalid is high for exactly one cycle, in cycle t+MEM_LAT, with that address's data.
- Reset values of all outputs: m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, mem_addr=0, stall_cnt=0.
- Reset deasserted at edge e: grants are possible in the cycle immediately after e. The first rvalid can occur MEM_LAT cycles after that.
- Reset asserted mid-stream: no rvalid appears from the next edge onward until fresh grants mature.
- A requester that drops req before gnt withdraws its request. No state is retained for it.

## Configuration
- ARB_RR_EN defined: round-robin. On a tie, grant the index ≠ last_gnt. Under sustained contention grants strictly alternate, so neither requester waits more than 1 cycle.
- ARB_RR_EN undefined: fixed priority. On a tie, m1 (data) always wins. m0 may starve. last_gnt is still maintained but does not affect arbitration.

## Test plan
- Reset, then m0 alone requests 0x0,0x4,0x8 in consecutive cycles -> m0_gnt high 3 cycles; mem_addr 0x0,0x4,0x8; m0_rvalid high in the following 3 cycles with ROM words 0,1,2; m1_rvalid stays 0; stall_cnt=0.
- Both request continuously (m0 0x10, m1 0x20), with ARB_RR_EN -> grants m0,m1,m0,m1…; rvalid alternates one cycle later; stall_cnt increments 1 per cycle.
- Same stimulus without ARB_RR_EN -> m1_gnt high every cycle, m0_gnt never high; stall_cnt counts every cycle.
- Idle after grant of 0x24 -> mem_addr holds 0x24; no rvalid after the single response.
- Grant m1 at cycle t, assert reset at t+1 (MEM_LAT=2 build) -> no m1_rvalid at t+2; all outputs at reset values.
- Preload stall_cnt near saturation via 65540 contention cycles -> stall_cnt reads 0xFFFF and holds.
